// File: rtl/lfsr_seed_gen.sv
// lfsr_seed_gen
//   Converts a step count into an LFSR state for BIST pattern generators.
//   On a rising edge of `start` the Fibonacci LFSR is reloaded with SEED and
//   stepped `count` times. The resulting state is then latched into `dp`,
//   and `done` pulses for one cycle.
//
// Parameters
//   WIDTH  : LFSR / dp width in bits (>= 2)
//   TAPS   : feedback mask; bit i set means lfsr[i] feeds the XOR
//   SEED   : LFSR start value (must be nonzero)
//   CWIDTH : width of the count input
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset
//   start  in   run request; only a sampled 0->1 transition launches a run
//   count  in   number of LFSR steps, sampled on the launch edge only
//   dp     out  latched LFSR result, held until the next completion or reset
//   done   out  one-cycle pulse when dp has just been updated
//   busy   out  high while a run is in progress
module lfsr_seed_gen #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] SEED   = 8'h01,
    parameter int               CWIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [CWIDTH-1:0] count,
    output logic [WIDTH-1:0]  dp,
    output logic              done,
    output logic              busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    lfsr_q, lfsr_d;
    logic [CWIDTH-1:0]   cnt_q, cnt_d;
    logic                start_dly_q, start_dly_d;
    logic [WIDTH-1:0]    dp_q, dp_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;

    logic                launch;
    logic [WIDTH-1:0]    lfsr_next;

    // Shift toward the MSB and feed the parity of the tapped bits into bit 0.
    assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};

    // Edge detect. start_dly tracks start in every state. As a result, a level
    // that is held through a whole run never relaunches.
    assign launch = start & ~start_dly_q;

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        start_dly_d = start;
        dp_d        = dp_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                if (launch) begin
                    cnt_d   = count;
                    lfsr_d  = SEED;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A launch request in this state, including the completion
                // cycle, is ignored on purpose. It is not queued.
                if (cnt_q != '0) begin
                    lfsr_d = lfsr_next;
                    cnt_d  = cnt_q - CWIDTH'(1);
                end else begin
                    dp_d    = lfsr_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            cnt_q       <= '0;
            start_dly_q <= 1'b0;
            dp_q        <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            start_dly_q <= start_dly_d;
            dp_q        <= dp_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign dp   = dp_q;
    assign done = done_q;
    assign busy = busy_q;

    // An all-zero seed locks the LFSR at zero forever.
    seed_nonzero_a: assert property (@(posedge clk) disable iff (reset) (SEED != '0))
        else $error("lfsr_seed_gen: SEED must be nonzero");

endmodule

// File: tb/tb_lfsr_seed_gen.sv
module tb_lfsr_seed_gen;

    logic        clk = 1'b0;
    logic        reset;

    // Default instance (8-bit, taps B8, seed 01)
    logic        start_a;
    logic [7:0]  count_a;
    logic [7:0]  dp_a;
    logic        done_a;
    logic        busy_a;

    // Wide instance (16-bit, taps B400, seed ACE1, 12-bit count)
    logic        start_b;
    logic [11:0] count_b;
    logic [15:0] dp_b;
    logic        done_b;
    logic        busy_b;

    // Period instance (same LFSR, 16-bit count so one run covers the full period)
    logic        start_c;
    logic [15:0] count_c;
    logic [15:0] dp_c;
    logic        done_c;
    logic        busy_c;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lfsr_seed_gen dut_a (
        .clk   (clk),
        .reset (reset),
        .start (start_a),
        .count (count_a),
        .dp    (dp_a),
        .done  (done_a),
        .busy  (busy_a)
    );

    lfsr_seed_gen #(
        .WIDTH  (16),
        .TAPS   (16'hB400),
        .SEED   (16'hACE1),
        .CWIDTH (12)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .start (start_b),
        .count (count_b),
        .dp    (dp_b),
        .done  (done_b),
        .busy  (busy_b)
    );

    lfsr_seed_gen #(
        .WIDTH  (16),
        .TAPS   (16'hB400),
        .SEED   (16'hACE1),
        .CWIDTH (16)
    ) dut_c (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .count (count_c),
        .dp    (dp_c),
        .done  (done_c),
        .busy  (busy_c)
    );

    // Reference for the 16-bit configuration: taps at bits 15, 13, 12 and 10.
    function automatic logic [15:0] model16(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start_a = 1'b0; count_a = '0;
        start_b = 1'b0; count_b = '0;
        start_c = 1'b0; count_c = '0;
        #3;
        tests_run++;
        if (dp_a !== 8'h00) begin tests_failed++; $display("FAIL reset_dp: got %h expected 00", dp_a); end
        tests_run++;
        if (done_a !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", done_a); end
        tests_run++;
        if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        @(negedge clk);
        reset = 1'b0;
        tick();
        $display("[TB] reset: dp=%h done=%b busy=%b", dp_a, done_a, busy_a);
    endtask

    task automatic test_count_zero();
        count_a = 8'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tests_run++;
        if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL zero_busy_e0: got %b expected 1", busy_a); end
        tests_run++;
        if (done_a !== 1'b0) begin tests_failed++; $display("FAIL zero_done_e0: got %b expected 0", done_a); end
        tick();
        tests_run++;
        if (done_a !== 1'b1) begin tests_failed++; $display("FAIL zero_done_e1: got %b expected 1", done_a); end
        tests_run++;
        if (dp_a !== 8'h01) begin tests_failed++; $display("FAIL zero_dp: got %h expected 01", dp_a); end
        tests_run++;
        if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL zero_busy_e1: got %b expected 0", busy_a); end
        tick();
        tests_run++;
        if (done_a !== 1'b0) begin tests_failed++; $display("FAIL zero_done_pulse: got %b expected 0", done_a); end
        tests_run++;
        if (dp_a !== 8'h01) begin tests_failed++; $display("FAIL zero_dp_hold: got %h expected 01", dp_a); end
        $display("[TB] count=0: dp=%h", dp_a);
    endtask

    task automatic test_counts();
        logic [7:0] n_tab [3];
        logic [7:0] e_tab [3];
        int edges;
        n_tab[0] = 8'd3; e_tab[0] = 8'h08;
        n_tab[1] = 8'd4; e_tab[1] = 8'h11;
        n_tab[2] = 8'd5; e_tab[2] = 8'h23;
        for (int k = 0; k < 3; k++) begin
            count_a = n_tab[k];
            start_a = 1'b1;
            tick();
            start_a = 1'b0;
            edges = 0;
            while (done_a !== 1'b1 && edges < 300) begin
                tick();
                edges++;
            end
            tests_run++;
            if (edges != int'(n_tab[k]) + 1) begin
                tests_failed++;
                $display("FAIL count_latency n=%0d: got %0d edges expected %0d", n_tab[k], edges, int'(n_tab[k]) + 1);
            end
            tests_run++;
            if (dp_a !== e_tab[k]) begin
                tests_failed++;
                $display("FAIL count_dp n=%0d: got %h expected %h", n_tab[k], dp_a, e_tab[k]);
            end
            tick();
            tests_run++;
            if (done_a !== 1'b0) begin
                tests_failed++;
                $display("FAIL count_pulse n=%0d: got %b expected 0", n_tab[k], done_a);
            end
            $display("[TB] count=%0d: dp=%h edges=%0d", n_tab[k], dp_a, edges);
        end
    endtask

    task automatic test_held_start();
        int dones;
        count_a = 8'd2;
        start_a = 1'b1;
        dones = 0;
        repeat (20) begin
            tick();
            if (done_a === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 1) begin tests_failed++; $display("FAIL held_single_run: got %0d dones expected 1", dones); end
        tests_run++;
        if (dp_a !== 8'h04) begin tests_failed++; $display("FAIL held_dp: got %h expected 04", dp_a); end
        start_a = 1'b0;
        tick();
        start_a = 1'b1;
        dones = 0;
        repeat (6) begin
            tick();
            if (done_a === 1'b1) dones++;
        end
        start_a = 1'b0;
        tests_run++;
        if (dones != 1) begin tests_failed++; $display("FAIL held_relaunch: got %0d dones expected 1", dones); end
        tick();
        $display("[TB] held start: dp=%h", dp_a);
    endtask

    task automatic test_back_to_back();
        int dones;
        int done_edge;
        count_a = 8'd10;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        count_a = 8'd0;   // must not affect the run in progress
        dones = 0;
        done_edge = -1;
        for (int e = 1; e <= 11; e++) begin
            if (e == 5) start_a = 1'b1;
            tick();
            if (e == 5) start_a = 1'b0;
            if (done_a === 1'b1) begin dones++; done_edge = e; end
        end
        tests_run++;
        if (dones != 1) begin tests_failed++; $display("FAIL busy_launch_dones: got %0d expected 1", dones); end
        tests_run++;
        if (done_edge != 11) begin tests_failed++; $display("FAIL busy_launch_edge: got %0d expected 11", done_edge); end
        tests_run++;
        if (dp_a !== 8'h71) begin tests_failed++; $display("FAIL busy_launch_dp: got %h expected 71", dp_a); end
        $display("[TB] count=10 with busy relaunch: dp=%h edge=%0d", dp_a, done_edge);

        // Launch in the cycle right after done
        count_a = 8'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        dones = 0;
        done_edge = -1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (done_a === 1'b1) begin dones++; done_edge = e; end
        end
        tests_run++;
        if (done_edge != 2 || dones != 1) begin
            tests_failed++;
            $display("FAIL b2b_edge: got edge %0d (%0d dones) expected edge 2 (1 done)", done_edge, dones);
        end
        tests_run++;
        if (dp_a !== 8'h02) begin tests_failed++; $display("FAIL b2b_dp: got %h expected 02", dp_a); end
        $display("[TB] back-to-back count=1: dp=%h", dp_a);
    endtask

    task automatic test_reset_mid_run();
        int dones;
        int edges;
        count_a = 8'd200;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (50) tick();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (dp_a !== 8'h00) begin tests_failed++; $display("FAIL abort_dp: got %h expected 00", dp_a); end
        tests_run++;
        if (busy_a !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b expected 0", busy_a); end
        tests_run++;
        if (done_a !== 1'b0) begin tests_failed++; $display("FAIL abort_done: got %b expected 0", done_a); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (210) begin
            tick();
            if (done_a === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0) begin tests_failed++; $display("FAIL abort_no_done: got %0d dones expected 0", dones); end

        count_a = 8'd4;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        edges = 0;
        while (done_a !== 1'b1 && edges < 300) begin
            tick();
            edges++;
        end
        tests_run++;
        if (edges != 5) begin tests_failed++; $display("FAIL abort_rerun_edges: got %0d expected 5", edges); end
        tests_run++;
        if (dp_a !== 8'h11) begin tests_failed++; $display("FAIL abort_rerun_dp: got %h expected 11", dp_a); end
        tick();
        $display("[TB] reset mid-run then count=4: dp=%h", dp_a);
    endtask

    task automatic test_release_high();
        int edges;
        #2;
        reset   = 1'b1;
        start_a = 1'b1;
        count_a = 8'd3;
        @(negedge clk);
        reset = 1'b0;
        tick();
        tests_run++;
        if (busy_a !== 1'b1) begin tests_failed++; $display("FAIL release_high_launch: got busy %b expected 1", busy_a); end
        edges = 0;
        while (done_a !== 1'b1 && edges < 300) begin
            tick();
            edges++;
        end
        tests_run++;
        if (edges != 4) begin tests_failed++; $display("FAIL release_high_edges: got %0d expected 4", edges); end
        tests_run++;
        if (dp_a !== 8'h08) begin tests_failed++; $display("FAIL release_high_dp: got %h expected 08", dp_a); end
        start_a = 1'b0;
        tick();
        $display("[TB] start high at reset release: dp=%h", dp_a);
    endtask

    task automatic test_wide();
        int edges;
        logic [15:0] exp_b;
        logic [15:0] exp_c;
        exp_b = model16(4095);
        count_b = 12'd4095;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        edges = 0;
        while (done_b !== 1'b1 && edges < 5000) begin
            tick();
            edges++;
        end
        tests_run++;
        if (edges != 4096) begin tests_failed++; $display("FAIL wide_edges: got %0d expected 4096", edges); end
        tests_run++;
        if (dp_b !== exp_b) begin tests_failed++; $display("FAIL wide_dp: got %h expected %h", dp_b, exp_b); end
        $display("[TB] wide count=4095: dp=%h", dp_b);

        // A maximal 16-bit LFSR returns to its seed after 65535 steps.
        exp_c = model16(65535);
        count_c = 16'd65535;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        edges = 0;
        while (done_c !== 1'b1 && edges < 70000) begin
            tick();
            edges++;
        end
        tests_run++;
        if (edges != 65536) begin tests_failed++; $display("FAIL period_edges: got %0d expected 65536", edges); end
        tests_run++;
        if (dp_c !== 16'hACE1) begin tests_failed++; $display("FAIL period_seed: got %h expected ace1", dp_c); end
        tests_run++;
        if (dp_c !== exp_c) begin tests_failed++; $display("FAIL period_model: got %h expected %h", dp_c, exp_c); end
        $display("[TB] period count=65535: dp=%h", dp_c);
    endtask

    initial begin
        test_reset();
        test_count_zero();
        test_counts();
        test_held_start();
        test_back_to_back();
        test_reset_mid_run();
        test_release_high();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
